// File: rtl/wf_rr_issue_scheduler_if.sv
// Issue-port bundle between the per-wavefront ready logic (master) and the
// round-robin scheduler (slave).
interface wf_rr_issue_scheduler_if #(
  parameter int NUM_WF  = 40,
  parameter int WF_ID_W = 6
);
  logic [NUM_WF-1:0]  req;
  logic               halt;
  logic               gnt_ack;
  logic               gnt_valid;
  logic [WF_ID_W-1:0] gnt_id;
  logic [NUM_WF-1:0]  gnt_onehot;
  logic [WF_ID_W-1:0] rr_ptr;

  modport master (
    output req, halt, gnt_ack,
    input  gnt_valid, gnt_id, gnt_onehot, rr_ptr
  );

  modport slave (
    input  req, halt, gnt_ack,
    output gnt_valid, gnt_id, gnt_onehot, rr_ptr
  );
endinterface

// File: rtl/wf_rr_issue_scheduler.sv
// Round-robin issue scheduler: one registered grant at a time across NUM_WF
// wavefront slots, pointer advances past the winner on each accepted grant.
module wf_rr_issue_scheduler #(
  parameter int NUM_WF  = 40,
  parameter int WF_ID_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wf_rr_issue_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [WF_ID_W:0]   NUM_WF_EXT = (WF_ID_W+1)'(NUM_WF);
  localparam logic [WF_ID_W-1:0] LAST_ID    = WF_ID_W'(NUM_WF-1);

  state_t              state, state_nxt;
  logic [WF_ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [WF_ID_W-1:0]  gnt_id, gnt_id_nxt;
  logic [NUM_WF-1:0]   gnt_onehot, gnt_onehot_nxt;
  logic [WF_ID_W-1:0]  ptr_after_gnt, arb_ptr, win_id;
  logic [NUM_WF-1:0]   arb_req, win_onehot;
  logic [WF_ID_W:0]    cand;
  logic                win_found;
  logic                holder_req;

  // One arbiter serves both cases: from rr_ptr when idle, and from the
  // post-ack pointer with the current holder masked out when granting.
  assign ptr_after_gnt = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
  assign arb_ptr       = (state == GRANT) ? ptr_after_gnt : rr_ptr;
  assign arb_req       = (state == GRANT) ? (bus.req & ~gnt_onehot) : bus.req;
  assign holder_req    = |(bus.req & gnt_onehot);

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      cand = {1'b0, arb_ptr} + (WF_ID_W+1)'(i);
      if (cand >= NUM_WF_EXT) cand = cand - NUM_WF_EXT;
      if (!win_found && arb_req[cand[WF_ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[WF_ID_W-1:0];
      end
    end
  end

  assign win_onehot = {{(NUM_WF-1){1'b0}}, 1'b1} << win_id;

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    gnt_id_nxt     = gnt_id;
    gnt_onehot_nxt = gnt_onehot;
    case (state)
      IDLE: begin
        if (!bus.halt && win_found) begin
          state_nxt      = GRANT;
          gnt_id_nxt     = win_id;
          gnt_onehot_nxt = win_onehot;
        end
      end
      GRANT: begin
        // An ack takes precedence over a simultaneous withdrawal.
        if (bus.gnt_ack) begin
          rr_ptr_nxt = ptr_after_gnt;
          if (!bus.halt && win_found) begin
            gnt_id_nxt     = win_id;
            gnt_onehot_nxt = win_onehot;
          end else begin
            state_nxt      = IDLE;
            gnt_onehot_nxt = '0;
          end
        end else if (!holder_req) begin
          state_nxt      = IDLE;
          gnt_onehot_nxt = '0;
        end
      end
      default: begin
        state_nxt      = IDLE;
        gnt_onehot_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      gnt_onehot <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      gnt_id     <= gnt_id_nxt;
      gnt_onehot <= gnt_onehot_nxt;
    end
  end

  assign bus.gnt_valid  = (state == GRANT);
  assign bus.gnt_id     = gnt_id;
  assign bus.gnt_onehot = gnt_onehot;
  assign bus.rr_ptr     = rr_ptr;

endmodule

// File: tb/tb_wf_rr_issue_scheduler.sv
// Bench for wf_rr_issue_scheduler: directed scenarios plus random traffic
// checked against a circular-search reference model with a starvation bound.
module tb_wf_rr_issue_scheduler;

  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;

  logic clk;
  logic rst_n;

  wf_rr_issue_scheduler_if #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) bus ();

  wf_rr_issue_scheduler #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assert_count = 0;
  int fail_count   = 0;

  bit m_valid;
  int m_id;
  int m_ptr;
  int wait_cnt [NUM_WF];
  int fair_tally [NUM_WF];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_WF-1:0] r, input int from);
    for (int k = 0; k < NUM_WF; k++) begin
      int s;
      s = (from + k) % NUM_WF;
      if (r[s]) return s;
    end
    return -1;
  endfunction

  function automatic logic [63:0] onehot_of(input int id);
    logic [63:0] v;
    v = 64'd1 << id;
    return v;
  endfunction

  task automatic modelReset();
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = 0;
    for (int s = 0; s < NUM_WF; s++) wait_cnt[s] = 0;
  endtask

  // Advance the reference by one clock edge given the inputs seen at that edge.
  task automatic modelStep(input logic [NUM_WF-1:0] r, input bit h, input bit a);
    logic [NUM_WF-1:0] masked;
    int w;
    for (int s = 0; s < NUM_WF; s++) begin
      if (!r[s]) wait_cnt[s] = 0;
      else if (m_valid && a) begin
        if (s == m_id) wait_cnt[s] = 0;
        else begin
          wait_cnt[s]++;
          checkOutput("starve_bound", 64'(wait_cnt[s] < NUM_WF), 64'd1);
        end
      end
    end
    if (!m_valid) begin
      w = pick(r, m_ptr);
      if (!h && w >= 0) begin
        m_valid = 1'b1;
        m_id    = w;
      end
    end else if (a) begin
      m_ptr = (m_id + 1) % NUM_WF;
      masked = r;
      masked[m_id] = 1'b0;
      w = pick(masked, m_ptr);
      if (!h && w >= 0) m_id = w;
      else m_valid = 1'b0;
    end else if (!r[m_id]) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compareAll();
    checkOutput("gnt_valid", 64'(bus.gnt_valid), 64'(m_valid));
    if (m_valid) checkOutput("gnt_id", 64'(bus.gnt_id), 64'(m_id));
    checkOutput("gnt_onehot", 64'(bus.gnt_onehot), m_valid ? onehot_of(m_id) : 64'd0);
    checkOutput("rr_ptr", 64'(bus.rr_ptr), 64'(m_ptr));
    checkOutput("onehot0", 64'($onehot0(bus.gnt_onehot)), 64'd1);
  endtask

  // Called at a falling edge: drive, let the DUT clock, then compare.
  task automatic applyStimulus(input logic [NUM_WF-1:0] r, input bit h, input bit a);
    bus.req     = r;
    bus.halt    = h;
    bus.gnt_ack = a;
    @(posedge clk);
    modelStep(r, h, a);
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    bus.req     = '0;
    bus.halt    = 1'b0;
    bus.gnt_ack = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    modelReset();
    rst_n = 1'b1;
    compareAll();
    checkOutput("reset_gnt_id", 64'(bus.gnt_id), 64'd0);
  endtask

  function automatic logic [NUM_WF-1:0] bits2(input int a, input int b);
    logic [NUM_WF-1:0] v;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [NUM_WF-1:0] bit1(input int a);
    logic [NUM_WF-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  logic [NUM_WF-1:0] rnd_req;
  logic [NUM_WF-1:0] all_ones;

  initial begin
    rst_n    = 1'b0;
    all_ones = '1;
    doReset();

    // Asynchronous reset while id 7 is granted.
    applyStimulus(bit1(7), 1'b0, 1'b0);
    checkOutput("t1_grant7", 64'(bus.gnt_id), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_async_valid", 64'(bus.gnt_valid), 64'd0);
    checkOutput("t1_async_ptr", 64'(bus.rr_ptr), 64'd0);
    checkOutput("t1_async_onehot", 64'(bus.gnt_onehot), 64'd0);
    @(negedge clk);
    doReset();

    // Basic grant sequence from pointer 0.
    applyStimulus(bits2(3, 10), 1'b0, 1'b0);
    checkOutput("t2_id3", 64'(bus.gnt_id), 64'd3);
    applyStimulus(bits2(3, 10), 1'b0, 1'b1);
    checkOutput("t2_ptr4", 64'(bus.rr_ptr), 64'd4);
    checkOutput("t2_id10", 64'(bus.gnt_id), 64'd10);
    applyStimulus(bit1(10), 1'b0, 1'b1);
    checkOutput("t2_ptr11", 64'(bus.rr_ptr), 64'd11);
    checkOutput("t2_idle", 64'(bus.gnt_valid), 64'd0);

    // Wrap-around: move pointer to 38 first.
    doReset();
    applyStimulus(bit1(37), 1'b0, 1'b0);
    applyStimulus(bit1(37), 1'b0, 1'b1);
    checkOutput("t3_ptr38", 64'(bus.rr_ptr), 64'd38);
    applyStimulus(bits2(39, 2), 1'b0, 1'b0);
    checkOutput("t3_id39", 64'(bus.gnt_id), 64'd39);
    applyStimulus(bits2(39, 2), 1'b0, 1'b1);
    checkOutput("t3_ptr0", 64'(bus.rr_ptr), 64'd0);
    checkOutput("t3_id2", 64'(bus.gnt_id), 64'd2);
    applyStimulus(bit1(2), 1'b0, 1'b1);
    checkOutput("t3_ptr3", 64'(bus.rr_ptr), 64'd3);

    // Hold without ack (halt toggling has no effect), withdraw, halt in IDLE.
    doReset();
    applyStimulus(bit1(5), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(bits2(5, 20), (i % 3) == 0, 1'b0);
      checkOutput("t4_hold5", 64'(bus.gnt_id), 64'd5);
    end
    applyStimulus(bit1(20), 1'b0, 1'b0);
    checkOutput("t4_withdraw", 64'(bus.gnt_valid), 64'd0);
    checkOutput("t4_ptr_same", 64'(bus.rr_ptr), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(all_ones, 1'b1, 1'b0);
      checkOutput("t4_halt", 64'(bus.gnt_valid), 64'd0);
    end

    // Fairness with every slot requesting and an ack every cycle.
    doReset();
    for (int s = 0; s < NUM_WF; s++) fair_tally[s] = 0;
    applyStimulus(all_ones, 1'b0, 1'b0);
    for (int k = 0; k < 2 * NUM_WF; k++) begin
      checkOutput("t5_valid", 64'(bus.gnt_valid), 64'd1);
      checkOutput("t5_order", 64'(bus.gnt_id), 64'(k % NUM_WF));
      if (int'(bus.gnt_id) < NUM_WF) fair_tally[bus.gnt_id]++;
      applyStimulus(all_ones, 1'b0, 1'b1);
    end
    for (int s = 0; s < NUM_WF; s++) checkOutput("t5_twice", 64'(fair_tally[s]), 64'd2);

    // Random traffic against the reference model.
    doReset();
    rnd_req = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 63) == 0) rnd_req = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) rnd_req[$urandom_range(0, NUM_WF-1)] ^= 1'b1;
      applyStimulus(rnd_req, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
